axis_line_source: RTL and testbench

AXIS_LINE_SOURCE -- requirements
Module: axis_line_source

---
 rtl/axis_line_source.sv | 131 +++++++++++++
 tb/tb_axis_line_source.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_line_source.sv
// rtl/axis_line_source.sv - AXI-Stream video test-pattern source, one frame per start request.
// Line/frame counters drive four selectable patterns with an optional idle gap between lines.
module axis_line_source #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int IMAGE_WIDTH            = 640,
    parameter int IMAGE_HEIGHT           = 480,
    parameter int LINE_GAP               = 4
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic                                  start,
    input  logic [1:0]                            pattern_sel,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    output logic                                  m00_axis_tuser,
    input  logic                                  m00_axis_tready
);

    localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int GW = (LINE_GAP     > 1) ? $clog2(LINE_GAP)     : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [GW-1:0] G_LAST = (LINE_GAP > 0) ? GW'(LINE_GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t          r_state, w_state_next;
    logic [XW-1:0]   r_x, w_x_next;
    logic [YW-1:0]   r_y, w_y_next;
    logic [GW-1:0]   r_gap, w_gap_next;
    logic [1:0]      r_pat, w_pat_next;
    logic            r_frame_done, w_frame_done_next;

    logic            w_send;
    logic            w_accept;
    logic [15:0]     w_x16, w_y16;
    logic [31:0]     w_pix;

    assign w_send   = (r_state == S_SEND);
    assign w_accept = w_send && m00_axis_tready;
    assign w_x16    = 16'(r_x);
    assign w_y16    = 16'(r_y);

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_gap        <= '0;
            r_pat        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_gap        <= w_gap_next;
            r_pat        <= w_pat_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_x_next          = r_x;
        w_y_next          = r_y;
        w_gap_next        = r_gap;
        w_pat_next        = r_pat;
        w_frame_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A start coinciding with the frame_done pulse is deliberately dropped.
                if (start && !r_frame_done) begin
                    w_state_next = S_SEND;
                    w_pat_next   = pattern_sel;
                    w_x_next     = '0;
                    w_y_next     = '0;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    if (r_x != X_LAST) begin
                        w_x_next = r_x + 1'b1;
                    end else begin
                        w_x_next = '0;
                        if (r_y == Y_LAST) begin
                            w_y_next          = '0;
                            w_state_next      = S_IDLE;
                            w_frame_done_next = 1'b1;
                        end else begin
                            w_y_next = r_y + 1'b1;
                            if (LINE_GAP > 0) begin
                                w_state_next = S_GAP;
                                w_gap_next   = '0;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap == G_LAST) w_state_next = S_SEND;
                else                 w_gap_next   = r_gap + 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pix = '0;
        case (r_pat)
            2'd0:    w_pix = 32'(r_x);
            2'd1:    w_pix = 32'(r_y);
            2'd2:    w_pix = {32{w_x16[3] ^ w_y16[3]}};
            default: w_pix = {w_y16, w_x16};
        endcase
    end

    // Beat outputs decode from registered state only, so they never follow tready.
    assign m00_axis_tvalid = w_send;
    assign m00_axis_tdata  = w_send ? w_pix : '0;
    assign m00_axis_tlast  = w_send && (r_x == X_LAST);
    assign m00_axis_tuser  = w_send && (r_x == '0) && (r_y == '0);
    assign m00_axis_tstrb  = '1;
    assign busy            = (r_state != S_IDLE);
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_axis_line_source.sv
// tb/tb_axis_line_source.sv - directed and randomized checks of axis_line_source against a pixel model.
module tb_axis_line_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n[2];
    logic        start[2];
    logic [1:0]  psel[2];
    logic        tready[2];
    logic        busy[2];
    logic        fdone[2];
    logic        tvalid[2];
    logic [31:0] tdata[2];
    logic [3:0]  tstrb[2];
    logic        tlast[2];
    logic        tuser[2];

    int P_W[2] = '{4, 16};
    int P_H[2] = '{2, 2};
    int P_G[2] = '{2, 0};

    int n_cmp = 0;
    int n_bad = 0;

    axis_line_source #(.C_M00_AXIS_TDATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .LINE_GAP(2)) u_a (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n[0]), .start(start[0]), .pattern_sel(psel[0]),
        .busy(busy[0]), .frame_done(fdone[0]), .m00_axis_tvalid(tvalid[0]), .m00_axis_tdata(tdata[0]),
        .m00_axis_tstrb(tstrb[0]), .m00_axis_tlast(tlast[0]), .m00_axis_tuser(tuser[0]),
        .m00_axis_tready(tready[0]));

    axis_line_source #(.C_M00_AXIS_TDATA_WIDTH(32), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(2), .LINE_GAP(0)) u_b (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n[1]), .start(start[1]), .pattern_sel(psel[1]),
        .busy(busy[1]), .frame_done(fdone[1]), .m00_axis_tvalid(tvalid[1]), .m00_axis_tdata(tdata[1]),
        .m00_axis_tstrb(tstrb[1]), .m00_axis_tlast(tlast[1]), .m00_axis_tuser(tuser[1]),
        .m00_axis_tready(tready[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_px(input int pat, input int x, input int y);
        case (pat)
            0:       return 32'(x);
            1:       return 32'(y);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 32'hFFFF_FFFF : 32'h0;
            default: return 32'((y % 65536) * 65536 + (x % 65536));
        endcase
    endfunction

    task automatic check_reset_outputs(input int u);
        check("rst_tvalid", 32'(tvalid[u]), 0);
        check("rst_busy",   32'(busy[u]),   0);
        check("rst_done",   32'(fdone[u]),  0);
        check("rst_tdata",  tdata[u],       0);
        check("rst_tlast",  32'(tlast[u]),  0);
        check("rst_tuser",  32'(tuser[u]),  0);
    endtask

    // rmode: 0 tready held high, 1 toggling 1,0,..., 2 random. disturb: repattern/restart mid-frame.
    task automatic run_frame(input int u, input int pat, input int rmode, input int disturb);
        logic [31:0] exp_q[$];
        logic [31:0] h_data;
        logic        h_last, h_user, hold;
        int          idx, last_c, n;
        bit          done;
        for (int y = 0; y < P_H[u]; y++)
            for (int x = 0; x < P_W[u]; x++)
                exp_q.push_back(model_px(pat, x, y));
        n = exp_q.size(); idx = 0; last_c = -1; hold = 1'b0; done = 1'b0;
        h_data = '0; h_last = 1'b0; h_user = 1'b0;
        @(negedge clk);
        psel[u] = pat[1:0]; start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (hold) begin
                check("hold_data", tdata[u], h_data);
                check("hold_last", 32'(tlast[u]), 32'(h_last));
                check("hold_user", 32'(tuser[u]), 32'(h_user));
            end
            if (idx == n) begin
                check("frame_done", 32'(fdone[u]), 1);
                check("idle_valid", 32'(tvalid[u]), 0);
                done = 1'b1;
                start[u] = 1'b1;
            end else begin
                check("busy", 32'(busy[u]), 1);
                check("no_early_done", 32'(fdone[u]), 0);
                case (rmode)
                    0:       tready[u] = 1'b1;
                    1:       tready[u] = (c % 2 == 0);
                    default: tready[u] = 1'($urandom_range(0, 1));
                endcase
                if (tvalid[u] && tready[u]) begin
                    check("tdata", tdata[u], exp_q[idx]);
                    check("tlast", 32'(tlast[u]), 32'((idx % P_W[u]) == P_W[u] - 1));
                    check("tuser", 32'(tuser[u]), 32'(idx == 0));
                    if (rmode == 0 && last_c >= 0)
                        check("beat_spacing", 32'(c - last_c), 32'(((idx % P_W[u]) == 0) ? P_G[u] + 1 : 1));
                    last_c = c;
                    idx++;
                end
                hold   = tvalid[u] && !tready[u];
                h_data = tdata[u]; h_last = tlast[u]; h_user = tuser[u];
                start[u] = 1'b0;
                if (disturb != 0 && idx == 3) begin
                    psel[u] = 2'd0; start[u] = 1'b1;
                end
            end
            @(negedge clk);
        end
        check("frame_completed", 32'(done), 1);
        start[u] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post_busy",  32'(busy[u]),   0);
            check("post_done",  32'(fdone[u]),  0);
            check("post_valid", 32'(tvalid[u]), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; start[u] = 1'b0; psel[u] = 2'd0; tready[u] = 1'b0;
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            check_reset_outputs(u);
            check("rst_tstrb", 32'(tstrb[u]), 32'hF);
        end
        @(negedge clk); @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        run_frame(0, 3, 0, 0);
        run_frame(0, 0, 1, 0);
        run_frame(0, 3, 0, 1);
        run_frame(1, 2, 0, 0);
        run_frame(1, 3, 2, 0);
        for (int r = 0; r < 4; r++) run_frame(0, int'($urandom_range(0, 3)), 2, 0);
        run_frame(1, int'($urandom_range(0, 3)), 2, 1);

        @(negedge clk);
        psel[0] = 2'd3; start[0] = 1'b1; tready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 5; c++) begin
            if (tvalid[0]) cnt++;
            if (cnt < 5) @(negedge clk);
        end
        check("beats_before_reset", 32'(cnt), 5);
        @(posedge clk);
        #2;
        check("midframe_valid", 32'(tvalid[0]), 1);
        rst_n[0] = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        check("reset_no_done", 32'(fdone[0]), 0);
        rst_n[0] = 1'b1;
        run_frame(0, 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
